spi_agc_master: RTL and testbench

SPI master engine for the AGC front-end. It consumes the control fields produced by the register stage (mode, command byte, per-channel data, channel select and start) and runs one 16-bit SPI transaction per start request to the selected AGC channel. On a read it returns the captured byte on `read_data`, which the register stage mirrors into its read-back register.

---
 rtl/spi_agc_master_pkg.sv | 23 ++
 rtl/spi_agc_master_if.sv | 36 +++
 rtl/spi_agc_clkdiv.sv | 42 ++++
 rtl/spi_agc_master.sv | 161 ++++++++++++++++
 tb/tb_spi_agc_master.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_agc_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_agc_pkg
// Brief    : Shared types and constants for the AGC SPI master engine.
// Revision : 1.0 - initial release
// ============================================================================
package spi_agc_pkg;

    // Transaction sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CTRL_MODE_SPI = 2'b01;
    localparam int         SPI_BITS      = 16;
    localparam int         CMD_BITS      = 8;

endpackage
`default_nettype wire

// File: rtl/spi_agc_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_agc_master_if
// Brief    : Control fields from the register stage plus the SPI pins.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_agc_master_if;
    import spi_agc_pkg::*;

    logic [1:0]          control_mode;
    logic [CMD_BITS-1:0] spi_mode;
    logic [CMD_BITS-1:0] spi_dataA;
    logic [CMD_BITS-1:0] spi_dataB;
    logic                channel;
    logic                start;
    logic                spi_miso;
    logic                spi_sclk;
    logic                spi_mosi;
    logic                spi_csn_a;
    logic                spi_csn_b;
    logic [CMD_BITS-1:0] read_data;
    logic                busy;
    logic                done;

    modport master (
        input  control_mode, spi_mode, spi_dataA, spi_dataB, channel, start, spi_miso,
        output spi_sclk, spi_mosi, spi_csn_a, spi_csn_b, read_data, busy, done
    );

    modport slave (
        output control_mode, spi_mode, spi_dataA, spi_dataB, channel, start, spi_miso,
        input  spi_sclk, spi_mosi, spi_csn_a, spi_csn_b, read_data, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/spi_agc_clkdiv.sv
`default_nettype none
// ============================================================================
// Module   : spi_agc_clkdiv
// Brief    : Half-period tick generator; restarts whenever enable drops.
// Revision : 1.0 - initial release
// ============================================================================
module spi_agc_clkdiv #(
    parameter int CLK_DIV = 4
) (
    input  wire logic main_clk,
    input  wire logic reg_reset_n,
    input  wire logic en_i,
    output logic      tick_o
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_LAST);

    // Count 0..CLK_DIV-1, wrapping on the tick and clearing while disabled
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Divider counter register
    always_ff @(posedge main_clk or negedge reg_reset_n) begin
        if (!reg_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_agc_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_agc_master
// Brief    : Mode-0 SPI master running one 16-bit command/data frame per
//            start request to the selected AGC channel.
// Revision : 1.0 - initial release
// ============================================================================
module spi_agc_master #(
    parameter int CLK_DIV = 4
) (
    input  wire logic        main_clk,
    input  wire logic        reg_reset_n,
    spi_agc_master_if.master agc
);
    import spi_agc_pkg::*;

    state_t              state_q, state_d;
    logic                start_q;
    logic [SPI_BITS-1:0] sreg_q, sreg_d;
    logic [CMD_BITS-1:0] cap_q, cap_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic                ch_q, ch_d;
    logic                rd_q, rd_d;
    logic                sclk_q, sclk_d;
    logic                csn_a_q, csn_a_d;
    logic                csn_b_q, csn_b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CMD_BITS-1:0] read_data_q, read_data_d;
    logic                req;
    logic                tick;
    logic                div_en;

    assign req    = agc.start & ~start_q;
    assign div_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    spi_agc_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .main_clk    (main_clk),
        .reg_reset_n (reg_reset_n),
        .en_i        (div_en),
        .tick_o      (tick)
    );

    // Next-state, shift/capture datapath and registered pin values
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cap_d       = cap_q;
        bit_cnt_d   = bit_cnt_q;
        ch_d        = ch_q;
        rd_d        = rd_q;
        sclk_d      = sclk_q;
        read_data_d = read_data_q;

        case (state_q)
            IDLE: begin
                if (req && (agc.control_mode == CTRL_MODE_SPI)) begin
                    state_d   = SETUP;
                    ch_d      = agc.channel;
                    rd_d      = agc.spi_mode[0];
                    // Reads shift zeros in the data phase
                    sreg_d    = {agc.spi_mode,
                                 agc.spi_mode[0] ? {CMD_BITS{1'b0}}
                                                 : (agc.channel ? agc.spi_dataB : agc.spi_dataA)};
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        // Rising edge: sample MISO during the data byte only
                        sclk_d = 1'b1;
                        if (rd_q && bit_cnt_q[3]) begin
                            cap_d = {cap_q[CMD_BITS-2:0], agc.spi_miso};
                        end
                    end else begin
                        // Falling edge: present the next MOSI bit
                        sclk_d = 1'b0;
                        sreg_d = {sreg_q[SPI_BITS-2:0], 1'b0};
                        if (bit_cnt_q == 4'(SPI_BITS - 1)) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        done_d  = (state_d == DONE);
        csn_a_d = !(busy_d && !ch_d);
        csn_b_d = !(busy_d && ch_d);
        if ((state_d == DONE) && rd_q) begin
            read_data_d = cap_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge main_clk or negedge reg_reset_n) begin
        if (!reg_reset_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            sreg_q      <= '0;
            cap_q       <= '0;
            bit_cnt_q   <= '0;
            ch_q        <= 1'b0;
            rd_q        <= 1'b0;
            sclk_q      <= 1'b0;
            csn_a_q     <= 1'b1;
            csn_b_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= agc.start;
            sreg_q      <= sreg_d;
            cap_q       <= cap_d;
            bit_cnt_q   <= bit_cnt_d;
            ch_q        <= ch_d;
            rd_q        <= rd_d;
            sclk_q      <= sclk_d;
            csn_a_q     <= csn_a_d;
            csn_b_q     <= csn_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_data_q <= read_data_d;
        end
    end

    assign agc.spi_sclk  = sclk_q;
    assign agc.spi_mosi  = sreg_q[SPI_BITS-1];
    assign agc.spi_csn_a = csn_a_q;
    assign agc.spi_csn_b = csn_b_q;
    assign agc.read_data = read_data_q;
    assign agc.busy      = busy_q;
    assign agc.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_agc_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_agc_master
// Brief    : Two instances (CLK_DIV=4 and CLK_DIV=2) driven by the same
//            stimulus, each checked every cycle against a frame-offset model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_agc_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tb_cmode = 2'b01;
    logic [7:0] tb_spi_mode = 8'h00;
    logic [7:0] tb_da = 8'h00;
    logic [7:0] tb_db = 8'h00;
    logic       tb_ch = 1'b0;
    logic       tb_start = 1'b0;
    logic [7:0] tb_rbyte = 8'h00;
    int         cyc = 0;

    int checks = 0;
    int failures = 0;

    logic       o_busy [2];
    logic       o_done [2];
    logic       o_csa  [2];
    logic       o_csb  [2];
    logic       o_sclk [2];
    logic       o_mosi [2];
    logic [7:0] o_rdata[2];

    logic [15:0] mon_stream [2];
    int          mon_rises  [2];
    int          mon_dones  [2];
    int          mon_done_abs[2][4];
    int          mon_csa    [2];
    int          mon_csb    [2];
    int          mon_busy   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h expected %0h", name, idx, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int H = (g == 0) ? 4 : 2;

        spi_agc_master_if ifc();
        logic       s_miso = 1'b0;
        int         s_cnt = 0;
        logic       s_prev = 1'b0;
        bit         m_active = 1'b0;
        int         m_E = 0;
        logic [15:0] m_frame = 16'h0;
        bit         m_ch = 1'b0;
        bit         m_rd = 1'b0;
        logic [7:0] m_rbyte = 8'h00;
        logic [7:0] m_rdata = 8'h00;
        bit         m_sprev = 1'b0;
        logic       mon_psclk = 1'b0;

        assign ifc.control_mode = tb_cmode;
        assign ifc.spi_mode     = tb_spi_mode;
        assign ifc.spi_dataA    = tb_da;
        assign ifc.spi_dataB    = tb_db;
        assign ifc.channel      = tb_ch;
        assign ifc.start        = tb_start;
        assign ifc.spi_miso     = s_miso;
        assign o_busy[g]  = ifc.busy;
        assign o_done[g]  = ifc.done;
        assign o_csa[g]   = ifc.spi_csn_a;
        assign o_csb[g]   = ifc.spi_csn_b;
        assign o_sclk[g]  = ifc.spi_sclk;
        assign o_mosi[g]  = ifc.spi_mosi;
        assign o_rdata[g] = ifc.read_data;

        spi_agc_master #(.CLK_DIV(H)) u_dut (
            .main_clk    (clk),
            .reg_reset_n (rst_n),
            .agc         (ifc)
        );

        // AGC slave: data byte bits 7..0 presented before rising edges 8..15, junk otherwise
        always @(negedge clk) begin
            if (o_csa[g] && o_csb[g]) s_cnt = 0;
            else if (o_sclk[g] && !s_prev) s_cnt++;
            s_prev = o_sclk[g];
            if (s_cnt >= 8 && s_cnt <= 15) s_miso = m_rbyte[15 - s_cnt];
            else s_miso = 1'($urandom_range(0, 1));
        end

        // Reference model (outputs as a function of cycle offset from accept) and compare
        always @(posedge clk) begin
            int   o;
            int   bi;
            logic ebusy, edone, ecsa, ecsb, esclk;
            if (!rst_n) begin
                m_active = 1'b0;
                m_sprev  = 1'b0;
                m_rdata  = 8'h00;
            end else begin
                if (m_active && (cyc - m_E) >= 33 * H + 2) m_active = 1'b0;
                if (!m_active && tb_start && !m_sprev && tb_cmode == 2'b01) begin
                    m_active = 1'b1;
                    m_E      = cyc;
                    m_ch     = tb_ch;
                    m_rd     = tb_spi_mode[0];
                    m_frame  = {tb_spi_mode, tb_spi_mode[0] ? 8'h00 : (tb_ch ? tb_db : tb_da)};
                    m_rbyte  = tb_rbyte;
                end
                m_sprev = tb_start;
            end
            #1;
            if (rst_n) begin
                o     = m_active ? (cyc - m_E) : -1;
                ebusy = (o >= 1) && (o <= 33 * H);
                edone = (o == 33 * H + 1);
                ecsa  = !(ebusy && !m_ch);
                ecsb  = !(ebusy && m_ch);
                esclk = (o >= 1 + H) && (o <= 32 * H) && ((((o - 1 - H) / H) % 2) == 0);
                if (edone && m_rd) m_rdata = m_rbyte;
                chk("ctl{busy,done,csa,csb,sclk}", g,
                    {27'd0, o_busy[g], o_done[g], o_csa[g], o_csb[g], o_sclk[g]},
                    {27'd0, ebusy, edone, ecsa, ecsb, esclk});
                chk("read_data", g, {24'd0, o_rdata[g]}, {24'd0, m_rdata});
                if (o >= 1 && o <= 32 * H) begin
                    bi = (o - 1) / (2 * H);
                    chk("mosi", g, {31'd0, o_mosi[g]}, {31'd0, m_frame[15 - bi]});
                end
                if (o_sclk[g] && !mon_psclk) begin
                    mon_stream[g] = {mon_stream[g][14:0], o_mosi[g]};
                    mon_rises[g]++;
                end
                if (o_done[g]) begin
                    if (mon_dones[g] < 4) mon_done_abs[g][mon_dones[g]] = cyc;
                    mon_dones[g]++;
                end
                if (!o_csa[g]) mon_csa[g]++;
                if (!o_csb[g]) mon_csb[g]++;
                if (o_busy[g]) mon_busy[g]++;
            end
            mon_psclk = o_sclk[g];
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            mon_stream[i] = 16'h0;
            mon_rises[i]  = 0;
            mon_dones[i]  = 0;
            mon_csa[i]    = 0;
            mon_csb[i]    = 0;
            mon_busy[i]   = 0;
            for (int j = 0; j < 4; j++) mon_done_abs[i][j] = -1;
        end
    endtask

    task automatic pulse_start(output int e);
        @(negedge clk);
        tb_start = 1'b1;
        e = cyc;
        @(negedge clk);
        tb_start = 1'b0;
    endtask

    function automatic int end_off(input int i);
        return (i == 0) ? 133 : 67;
    endfunction

    function automatic int cs_cycles(input int i);
        return (i == 0) ? 132 : 66;
    endfunction

    initial begin
        int e;
        clear_mon();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("reset_state", i,
                {o_busy[i], o_done[i], o_csa[i], o_csb[i], o_sclk[i], o_mosi[i], o_rdata[i]},
                {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Write, channel A
        clear_mon();
        tb_cmode = 2'b01; tb_spi_mode = 8'hAA; tb_da = 8'hF3; tb_db = 8'h3C; tb_ch = 1'b0;
        pulse_start(e);
        repeat (140) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("wr_stream", i, {16'd0, mon_stream[i]}, 32'h0000AAF3);
            chk("wr_rises", i, mon_rises[i], 16);
            chk("wr_dones", i, mon_dones[i], 1);
            chk("wr_done_cycle", i, mon_done_abs[i][0] - e, end_off(i));
            chk("wr_csa_cycles", i, mon_csa[i], cs_cycles(i));
            chk("wr_csb_cycles", i, mon_csb[i], 0);
            chk("wr_read_data", i, {24'd0, o_rdata[i]}, 32'h0);
        end

        // Read, channel B
        clear_mon();
        tb_spi_mode = 8'h25; tb_ch = 1'b1; tb_rbyte = 8'h5C;
        pulse_start(e);
        repeat (140) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rd_stream", i, {16'd0, mon_stream[i]}, 32'h00002500);
            chk("rd_read_data", i, {24'd0, o_rdata[i]}, 32'h5C);
            chk("rd_csa_cycles", i, mon_csa[i], 0);
            chk("rd_csb_cycles", i, mon_csb[i], cs_cycles(i));
            chk("rd_dones", i, mon_dones[i], 1);
        end

        // Gated by control_mode
        clear_mon();
        tb_cmode = 2'b10; tb_spi_mode = 8'h10; tb_ch = 1'b0;
        pulse_start(e);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("gate_dones", i, mon_dones[i], 0);
            chk("gate_busy", i, mon_busy[i], 0);
            chk("gate_cs", i, mon_csa[i] + mon_csb[i], 0);
        end
        tb_cmode = 2'b01;

        // Second start edge at E+50 is dropped
        clear_mon();
        tb_spi_mode = 8'h42; tb_da = 8'h81;
        pulse_start(e);
        repeat (49) @(negedge clk);
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        repeat (150) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("restart_dones", i, mon_dones[i], 1);

        // Start held high through completion
        clear_mon();
        @(negedge clk);
        tb_start = 1'b1;
        repeat (300) @(negedge clk);
        tb_start = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("held_dones", i, mon_dones[i], 1);

        // Reset at E+60
        clear_mon();
        tb_spi_mode = 8'h33; tb_rbyte = 8'hA7;
        pulse_start(e);
        repeat (59) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            chk("midrst_pins{csa,csb,sclk,busy}", i,
                {28'd0, o_csa[i], o_csb[i], o_sclk[i], o_busy[i]}, 32'hC);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (140) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("midrst_dones", i, mon_dones[i], 0);
        clear_mon();
        tb_spi_mode = 8'h5A; tb_da = 8'h96;
        pulse_start(e);
        repeat (140) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_dones", i, mon_dones[i], 1);
            chk("post_rst_stream", i, {16'd0, mon_stream[i]}, 32'h00005A96);
        end

        // Back-to-back at the first legal cycle for CLK_DIV=2 (E+68)
        clear_mon();
        tb_spi_mode = 8'hC6; tb_da = 8'h0F;
        pulse_start(e);
        repeat (67) @(negedge clk);
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        repeat (150) @(negedge clk);
        chk("b2b_dones", 1, mon_dones[1], 2);
        chk("b2b_done0", 1, mon_done_abs[1][0] - e, 67);
        chk("b2b_done1", 1, mon_done_abs[1][1] - e, 68 + 67);
        chk("b2b_dones", 0, mon_dones[0], 1);
        chk("b2b_done0", 0, mon_done_abs[0][0] - e, 133);

        // Randomized traffic, checked cycle by cycle by the model
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            tb_cmode    = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            tb_spi_mode = 8'($urandom);
            tb_da       = 8'($urandom);
            tb_db       = 8'($urandom);
            tb_ch       = 1'($urandom_range(0, 1));
            tb_rbyte    = 8'($urandom);
            tb_start    = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            tb_start = 1'b0;
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        repeat (150) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
